// File: rtl/wvb_storage_ring_pkg.sv
// Shared types and derived widths for the waveform storage ring.
package wvb_storage_ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wvb_state_e;

  // Header FIFO word: {user header, start addr, stop addr, full-width stop pointer}
  function automatic int hdr_word_width(int hdr_w, int adr_w);
    return hdr_w + 3 * adr_w + 1;
  endfunction

endpackage

// File: rtl/wvb_hdr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module wvb_hdr_fifo #(
  parameter int P_WIDTH       = 8,
  parameter int P_DEPTH_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [P_WIDTH-1:0]       din,
  output logic [P_WIDTH-1:0]       dout,
  output logic                     empty,
  output logic                     full,
  output logic [P_DEPTH_WIDTH:0]   count
);
  localparam logic [P_DEPTH_WIDTH:0] DEPTH = {1'b1, {P_DEPTH_WIDTH{1'b0}}};

  logic [P_WIDTH-1:0]       mem [2**P_DEPTH_WIDTH];
  logic [P_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_WIDTH:0]   count_q, count_d;
  logic                     do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    do_push  = push && !rst && ((count_q != DEPTH) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/wvb_storage_ring.sv
// Circular waveform sample RAM with header FIFO, space-checked acceptance and drop counting.
//   state  | meaning
//   IDLE   | waiting for a sof sample
//   WRITE  | storing samples of an accepted waveform
//   DROP   | discarding the rest of a rejected waveform until eoe
module wvb_storage_ring
  import wvb_storage_ring_pkg::*;
#(
  parameter int P_DATA_WIDTH      = 22,
  parameter int P_ADR_WIDTH       = 12,
  parameter int P_HDR_WIDTH       = 80,
  parameter int P_HDR_DEPTH_WIDTH = 8,
  parameter int P_OVF_CNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [P_DATA_WIDTH-1:0]              wvb_data_in,
  input  logic                                 wvb_wrreq,
  input  logic                                 sof_in,
  input  logic                                 eoe_in,
  input  logic [P_HDR_WIDTH-1:0]               hdr_data_in,
  input  logic [P_ADR_WIDTH-1:0]               wvb_rd_addr,
  output logic [P_DATA_WIDTH-1:0]              wvb_data_out,
  input  logic                                 hdr_rdreq,
  input  logic                                 rd_done,
  output logic [P_HDR_WIDTH+2*P_ADR_WIDTH-1:0] hdr_data_out,
  output logic                                 hdr_empty,
  output logic                                 hdr_full,
  output logic [P_HDR_DEPTH_WIDTH:0]           n_wvf_in_buf,
  output logic [P_OVF_CNT_WIDTH-1:0]           ovf_cnt,
  output logic                                 drop_pulse
);
  localparam int FW = hdr_word_width(P_HDR_WIDTH, P_ADR_WIDTH);
  localparam logic [P_ADR_WIDTH:0] RAM_DEPTH = {1'b1, {P_ADR_WIDTH{1'b0}}};
  localparam logic [P_ADR_WIDTH:0] PTR_ONE   = {{P_ADR_WIDTH{1'b0}}, 1'b1};

  wvb_state_e                 state_q, state_d;
  logic [P_ADR_WIDTH:0]       wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [P_ADR_WIDTH:0]       rel_ptr_q, rel_ptr_d, stop_lat_q, stop_lat_d, base_ptr;
  logic [P_ADR_WIDTH-1:0]     start_q, start_d, push_start;
  logic                       rel_arm_q, rel_arm_d, drop_pulse_q, drop_pulse_d;
  logic [P_OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [P_OVF_CNT_WIDTH:0]   ovf_sum;
  logic [1:0]                 n_drop;
  logic                       restart, ram_full, pop, push, mem_we;
  logic [P_DATA_WIDTH-1:0]    mem [2**P_ADR_WIDTH];
  logic [P_DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [FW-1:0]              fifo_din, fifo_dout;
  logic                       unused_data_bit0;

  assign unused_data_bit0 = wvb_data_in[0];
  assign pop = hdr_rdreq && !hdr_empty;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    start_d      = start_q;
    push_start   = start_q;
    mem_we       = 1'b0;
    push         = 1'b0;
    n_drop       = 2'd0;
    // A sof inside WRITE rewinds to the last committed pointer before being evaluated.
    restart  = wvb_wrreq && sof_in && (state_q == ST_WRITE);
    base_ptr = restart ? commit_ptr_q : wr_ptr_q;
    ram_full = ((base_ptr - rel_ptr_q) == RAM_DEPTH);
    if (wvb_wrreq) begin
      if (sof_in && (state_q != ST_DROP)) begin
        wr_ptr_d = base_ptr;
        if (restart) n_drop = 2'd1;
        if ((hdr_full && !pop) || ram_full) begin
          n_drop  = n_drop + 2'd1;
          state_d = eoe_in ? ST_IDLE : ST_DROP;
        end else begin
          mem_we     = 1'b1;
          start_d    = base_ptr[P_ADR_WIDTH-1:0];
          push_start = base_ptr[P_ADR_WIDTH-1:0];
          wr_ptr_d   = base_ptr + PTR_ONE;
          if (eoe_in) begin
            push         = 1'b1;
            commit_ptr_d = base_ptr + PTR_ONE;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end else if (state_q == ST_WRITE) begin
        if (ram_full) begin
          wr_ptr_d = commit_ptr_q;
          n_drop   = 2'd1;
          state_d  = eoe_in ? ST_IDLE : ST_DROP;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = base_ptr + PTR_ONE;
          if (eoe_in) begin
            push         = 1'b1;
            commit_ptr_d = base_ptr + PTR_ONE;
            state_d      = ST_IDLE;
          end
        end
      end else if ((state_q == ST_DROP) && eoe_in) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    rel_ptr_d  = rel_ptr_q;
    rel_arm_d  = rel_arm_q;
    stop_lat_d = stop_lat_q;
    // Only the first rd_done after a pop releases space.
    if (rd_done && rel_arm_q) begin
      rel_ptr_d = stop_lat_q + PTR_ONE;
      rel_arm_d = 1'b0;
    end
    if (pop) begin
      stop_lat_d = fifo_dout[P_ADR_WIDTH:0];
      rel_arm_d  = 1'b1;
    end
    ovf_sum      = {1'b0, ovf_cnt_q} + {{(P_OVF_CNT_WIDTH-1){1'b0}}, n_drop};
    ovf_cnt_d    = ovf_sum[P_OVF_CNT_WIDTH] ? '1 : ovf_sum[P_OVF_CNT_WIDTH-1:0];
    drop_pulse_d = (n_drop != 2'd0);
    rd_data_d    = mem[wvb_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rel_ptr_q    <= '0;
      stop_lat_q   <= '0;
      start_q      <= '0;
      rel_arm_q    <= 1'b0;
      ovf_cnt_q    <= '0;
      drop_pulse_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rel_ptr_q    <= rel_ptr_d;
      stop_lat_q   <= stop_lat_d;
      start_q      <= start_d;
      rel_arm_q    <= rel_arm_d;
      ovf_cnt_q    <= ovf_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[base_ptr[P_ADR_WIDTH-1:0]] <= {wvb_data_in[P_DATA_WIDTH-1:1], eoe_in};
  end

  assign fifo_din = {hdr_data_in, push_start, base_ptr[P_ADR_WIDTH-1:0], base_ptr};

  wvb_hdr_fifo #(
    .P_WIDTH       (FW),
    .P_DEPTH_WIDTH (P_HDR_DEPTH_WIDTH)
  ) u_hdr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (hdr_empty),
    .full  (hdr_full),
    .count (n_wvf_in_buf)
  );

  assign hdr_data_out = fifo_dout[FW-1:P_ADR_WIDTH+1];
  assign wvb_data_out = rd_data_q;
  assign ovf_cnt      = ovf_cnt_q;
  assign drop_pulse   = drop_pulse_q;

endmodule

// File: tb/tb_wvb_storage_ring.sv
// Directed bench for wvb_storage_ring with a 16-entry RAM, 4-entry header FIFO, 3-bit drop counter.
module tb_wvb_storage_ring;
  localparam int DW = 22, AW = 4, HW = 16, HDW = 2, OW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     wvb_data_in;
  logic              wvb_wrreq, sof_in, eoe_in;
  logic [HW-1:0]     hdr_data_in;
  logic [AW-1:0]     wvb_rd_addr;
  logic [DW-1:0]     wvb_data_out;
  logic              hdr_rdreq, rd_done;
  logic [HW+2*AW-1:0] hdr_data_out;
  logic              hdr_empty, hdr_full;
  logic [HDW:0]      n_wvf_in_buf;
  logic [OW-1:0]     ovf_cnt;
  logic              drop_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  typedef struct {
    int          len;
    logic [15:0] hdr;
    int          exp_n;
    logic        exp_full;
    int          exp_ovf;
    logic [23:0] exp_head;
  } vec_t;

  wvb_storage_ring #(
    .P_DATA_WIDTH      (DW),
    .P_ADR_WIDTH       (AW),
    .P_HDR_WIDTH       (HW),
    .P_HDR_DEPTH_WIDTH (HDW),
    .P_OVF_CNT_WIDTH   (OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wvb_data_in  (wvb_data_in),
    .wvb_wrreq    (wvb_wrreq),
    .sof_in       (sof_in),
    .eoe_in       (eoe_in),
    .hdr_data_in  (hdr_data_in),
    .wvb_rd_addr  (wvb_rd_addr),
    .wvb_data_out (wvb_data_out),
    .hdr_rdreq    (hdr_rdreq),
    .rd_done      (rd_done),
    .hdr_data_out (hdr_data_out),
    .hdr_empty    (hdr_empty),
    .hdr_full     (hdr_full),
    .n_wvf_in_buf (n_wvf_in_buf),
    .ovf_cnt      (ovf_cnt),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (drop_pulse === 1'b1) n_pulses <= n_pulses + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] sdat(int w, int i);
    return {w[7:0], i[12:0], 1'b1};
  endfunction

  function automatic logic [21:0] rdat(int w, int i, logic e);
    logic [21:0] t;
    t = sdat(w, i);
    t[0] = e;
    return t;
  endfunction

  function automatic logic [23:0] hd(logic [15:0] h, int s, int e);
    return {h, s[3:0], e[3:0]};
  endfunction

  task automatic drive(logic wr, logic s, logic e, logic [21:0] d, logic [15:0] h);
    @(negedge clk);
    wvb_wrreq = wr; sof_in = s; eoe_in = e; wvb_data_in = d; hdr_data_in = h;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic send_wave(int len, logic [15:0] h, int w);
    for (int i = 0; i < len; i++) drive(1'b1, i == 0, i == len - 1, sdat(w, i), h);
    idle();
  endtask

  task automatic pop();
    @(negedge clk); hdr_rdreq = 1'b1;
    @(negedge clk); hdr_rdreq = 1'b0;
  endtask

  task automatic release_wave();
    @(negedge clk); rd_done = 1'b1;
    @(negedge clk); rd_done = 1'b0;
  endtask

  task automatic rd_ram(int a, output logic [21:0] d);
    @(negedge clk); wvb_rd_addr = a[3:0];
    @(negedge clk); d = wvb_data_out;
  endtask

  task automatic check_reset(string tag);
    check({tag, " hdr_empty"}, 64'(hdr_empty), 64'(1));
    check({tag, " hdr_full"}, 64'(hdr_full), 64'(0));
    check({tag, " n_wvf"}, 64'(n_wvf_in_buf), 64'(0));
    check({tag, " ovf_cnt"}, 64'(ovf_cnt), 64'(0));
    check({tag, " drop_pulse"}, 64'(drop_pulse), 64'(0));
    check({tag, " wvb_data_out"}, 64'(wvb_data_out), 64'(0));
    check({tag, " hdr_data_out"}, 64'(hdr_data_out), 64'(0));
  endtask

  initial begin
    vec_t        vecs [5];
    logic [23:0] drain [4];
    logic [21:0] d;
    int          pc0;

    vecs[0] = '{2, 16'h0D01, 1, 1'b0, 1, hd(16'h0D01, 4, 5)};
    vecs[1] = '{2, 16'h0D02, 2, 1'b0, 1, hd(16'h0D01, 4, 5)};
    vecs[2] = '{2, 16'h0D03, 3, 1'b0, 1, hd(16'h0D01, 4, 5)};
    vecs[3] = '{2, 16'h0D04, 4, 1'b1, 1, hd(16'h0D01, 4, 5)};
    vecs[4] = '{2, 16'h0D05, 4, 1'b1, 2, hd(16'h0D01, 4, 5)};
    drain[0] = hd(16'h0D02, 6, 7);
    drain[1] = hd(16'h0D03, 8, 9);
    drain[2] = hd(16'h0D04, 10, 11);
    drain[3] = hd(16'h0D06, 12, 12);

    rst = 1'b1; wvb_data_in = '0; wvb_wrreq = 1'b0; sof_in = 1'b0; eoe_in = 1'b0;
    hdr_data_in = '0; wvb_rd_addr = '0; hdr_rdreq = 1'b0; rd_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Single 10-sample waveform
    send_wave(10, 16'h0ABC, 1);
    check("a head", 64'(hdr_data_out), 64'(hd(16'h0ABC, 0, 9)));
    check("a n_wvf", 64'(n_wvf_in_buf), 64'(1));
    check("a empty", 64'(hdr_empty), 64'(0));
    for (int i = 0; i < 10; i++) begin
      rd_ram(i, d);
      check("a ram", 64'(d), 64'(rdat(1, i, i == 9)));
    end
    pop();
    release_wave();
    check("a drained", 64'(hdr_empty), 64'(1));

    // sof and eoe together, then the next waveform follows at +1
    send_wave(1, 16'h0111, 2);
    check("b single head", 64'(hdr_data_out), 64'(hd(16'h0111, 10, 10)));
    rd_ram(10, d);
    check("b single ram", 64'(d), 64'(rdat(2, 0, 1'b1)));
    send_wave(2, 16'h0222, 3);
    check("b n_wvf", 64'(n_wvf_in_buf), 64'(2));
    pop();
    check("b second head", 64'(hdr_data_out), 64'(hd(16'h0222, 11, 12)));
    pop();
    release_wave();
    check("b drained", 64'(hdr_empty), 64'(1));

    // RAM overflow drop and wrap-around after release
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_wave(12, 16'h0C01, 4);
    pc0 = n_pulses;
    send_wave(8, 16'h0C02, 5);
    idle();
    check("c ovf_cnt", 64'(ovf_cnt), 64'(1));
    check("c n_wvf", 64'(n_wvf_in_buf), 64'(1));
    check("c head", 64'(hdr_data_out), 64'(hd(16'h0C01, 0, 11)));
    check("c drop pulses", 64'(n_pulses - pc0), 64'(1));
    pop();
    release_wave();
    send_wave(8, 16'h0C03, 6);
    check("c wrap head", 64'(hdr_data_out), 64'(hd(16'h0C03, 12, 3)));
    check("c wrap ovf", 64'(ovf_cnt), 64'(1));
    rd_ram(3, d);
    check("c ram 3", 64'(d), 64'(rdat(6, 7, 1'b1)));
    rd_ram(0, d);
    check("c ram 0", 64'(d), 64'(rdat(6, 4, 1'b0)));
    rd_ram(12, d);
    check("c ram 12", 64'(d), 64'(rdat(6, 0, 1'b0)));
    pop();
    release_wave();

    // Header FIFO fill, table-driven
    for (int k = 0; k < 5; k++) begin
      send_wave(vecs[k].len, vecs[k].hdr, 10 + k);
      check("d n_wvf", 64'(n_wvf_in_buf), 64'(vecs[k].exp_n));
      check("d full", 64'(hdr_full), 64'(vecs[k].exp_full));
      check("d ovf", 64'(ovf_cnt), 64'(vecs[k].exp_ovf));
      check("d head", 64'(hdr_data_out), 64'(vecs[k].exp_head));
    end
    // Pop from full FIFO together with a push
    @(negedge clk);
    wvb_wrreq = 1'b1; sof_in = 1'b1; eoe_in = 1'b1; wvb_data_in = sdat(16, 0);
    hdr_data_in = 16'h0D06; hdr_rdreq = 1'b1;
    @(negedge clk);
    wvb_wrreq = 1'b0; sof_in = 1'b0; eoe_in = 1'b0; hdr_rdreq = 1'b0;
    check("d push+pop n_wvf", 64'(n_wvf_in_buf), 64'(4));
    check("d push+pop full", 64'(hdr_full), 64'(1));
    check("d push+pop ovf", 64'(ovf_cnt), 64'(2));
    for (int k = 0; k < 4; k++) begin
      check("d drain head", 64'(hdr_data_out), 64'(drain[k]));
      pop();
    end
    release_wave();
    check("d drained", 64'(n_wvf_in_buf), 64'(0));

    // sof in the middle of a waveform
    drive(1'b1, 1'b1, 1'b0, sdat(20, 0), '0);
    drive(1'b1, 1'b0, 1'b0, sdat(20, 1), '0);
    drive(1'b1, 1'b0, 1'b0, sdat(20, 2), '0);
    drive(1'b1, 1'b1, 1'b0, sdat(21, 0), '0);
    drive(1'b1, 1'b0, 1'b0, sdat(21, 1), '0);
    drive(1'b1, 1'b0, 1'b1, sdat(21, 2), 16'h0E01);
    idle();
    check("e ovf", 64'(ovf_cnt), 64'(3));
    check("e head", 64'(hdr_data_out), 64'(hd(16'h0E01, 13, 15)));
    check("e n_wvf", 64'(n_wvf_in_buf), 64'(1));
    rd_ram(13, d);
    check("e ram 13", 64'(d), 64'(rdat(21, 0, 1'b0)));
    rd_ram(15, d);
    check("e ram 15", 64'(d), 64'(rdat(21, 2, 1'b1)));
    pop();
    release_wave();

    // Drop counter saturation through repeated restarts
    pc0 = n_pulses;
    drive(1'b1, 1'b1, 1'b0, sdat(30, 0), '0);
    for (int k = 1; k < 5; k++) drive(1'b1, 1'b1, 1'b0, sdat(30, k), '0);
    drive(1'b1, 1'b1, 1'b1, sdat(31, 0), 16'h0F01);
    check("s ovf at max", 64'(ovf_cnt), 64'(7));
    idle();
    check("s ovf saturated", 64'(ovf_cnt), 64'(7));
    check("s drop_pulse at saturation", 64'(drop_pulse), 64'(1));
    check("s head", 64'(hdr_data_out), 64'(hd(16'h0F01, 0, 0)));
    idle();
    idle();
    check("s drop pulses", 64'(n_pulses - pc0), 64'(5));

    // Reset during WRITE, then samples without sof
    drive(1'b1, 1'b1, 1'b0, sdat(40, 0), '0);
    drive(1'b1, 1'b0, 1'b0, sdat(40, 1), '0);
    @(negedge clk);
    rst = 1'b1; wvb_data_in = sdat(40, 2);
    @(negedge clk);
    rst = 1'b0;
    check_reset("f");
    wvb_data_in = sdat(40, 3);
    drive(1'b1, 1'b0, 1'b1, sdat(40, 4), 16'h0F0F);
    idle();
    idle();
    check("f ignored empty", 64'(hdr_empty), 64'(1));
    check("f ignored n_wvf", 64'(n_wvf_in_buf), 64'(0));
    send_wave(1, 16'h0F02, 41);
    check("f fresh head", 64'(hdr_data_out), 64'(hd(16'h0F02, 0, 0)));
    rd_ram(0, d);
    check("f fresh ram", 64'(d), 64'(rdat(41, 0, 1'b1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
